mem_port_arbiter: RTL and testbench

- Shares one single-ported 32-bit word memory between the instruction-fetch port (IF, read-only) and the data-memory stage (DM, read/write).
- Sits between the IF/MEM stages and the memory macro or external SRAM.
- Serialises accesses, inserts a fixed number of wait states, and returns per-port data with a one-cycle ready pulse.
- Drives a pipeline freeze until every pending request of the current pipeline step has been served.

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported word memory between the IF (read) and DM (read/write) ports.
// Latency: ready pulses WAIT_CYCLES+2 cycles after an uncontended request; accesses spaced WAIT_CYCLES+3.
// Backpressure: requests are level-held; pipe_freeze holds the pipeline until every pending request is served.
module mem_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ready,
  output logic              pipe_freeze,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state, stateNext;
  logic [3:0]         waitCnt;
  logic               grantDm, lastGrantDm;
  logic               ifDone, dmDone;
  logic [ADDR_W-1:0]  latAddr;
  logic               latWe;
  logic [31:0]        latWdata;
  logic               ifElig, dmElig, pickDm;

  // Byte-lane bits and bits above the memory size are deliberately ignored.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                            dm_addr[31:ADDR_W+2], dm_addr[1:0]};

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Eligibility, arbitration, next state and all memory/handshake outputs.
  always_comb begin
    ifElig      = if_req & ~ifDone;
    dmElig      = dm_req & ~dmDone;
    // DM wins a tie unless it won the previous tie-free or contended access.
    pickDm      = dmElig & (~ifElig | ~lastGrantDm);
    stateNext   = state;
    sram_en     = 1'b0;
    sram_we     = 1'b0;
    if_ready    = 1'b0;
    dm_ready    = 1'b0;
    sram_addr   = latAddr;
    sram_wdata  = latWdata;
    case (state)
      IDLE:   if (ifElig | dmElig) stateNext = ACCESS;
      ACCESS: begin
        sram_en = 1'b1;
        sram_we = latWe;
        if (waitCnt == 4'd0) stateNext = RESP;
      end
      RESP: begin
        if_ready  = ~grantDm;
        dm_ready  = grantDm;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // A port counts as served in the cycle its ready pulses, so the freeze drops there.
    pipe_freeze = (if_req & ~(ifDone | if_ready)) | (dm_req & ~(dmDone | dm_ready));
  end

  // Grant latching, wait-state counting and read-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitCnt     <= '0;
      grantDm     <= 1'b0;
      lastGrantDm <= 1'b0;
      latAddr     <= '0;
      latWe       <= 1'b0;
      latWdata    <= '0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
    end else begin
      case (state)
        IDLE: if (ifElig | dmElig) begin
          grantDm  <= pickDm;
          latAddr  <= pickDm ? dm_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
          latWe    <= pickDm & dm_we;
          latWdata <= pickDm ? dm_wdata : 32'd0;
          waitCnt  <= 4'(WAIT_CYCLES);
        end
        ACCESS: begin
          if (waitCnt != 4'd0) begin
            waitCnt <= waitCnt - 4'd1;
          end else begin
            lastGrantDm <= grantDm;
            if (!grantDm)    if_rdata <= sram_rdata;
            else if (!latWe) dm_rdata <= sram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Done bits stop a served, still-held request being re-issued within one pipeline step;
  // they clear whenever the pipeline is allowed to advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifDone <= 1'b0;
      dmDone <= 1'b0;
    end else if (!pipe_freeze) begin
      ifDone <= 1'b0;
      dmDone <= 1'b0;
    end else if (state == RESP) begin
      if (grantDm) dmDone <= 1'b1;
      else         ifDone <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed scoreboard bench for mem_port_arbiter (WAIT_CYCLES=1 and WAIT_CYCLES=0 instances).
// Latency: expected ready cycles are hand-computed and queued at stimulus time.
// Backpressure: requests are held until the expected ready cycle, then dropped as the pipeline advances.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        isDm;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   weCnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Instance A: WAIT_CYCLES = 1
  logic        aIfReq, aIfReady, aDmReq, aDmWe, aDmReady, aFreeze, aEn, aWe;
  logic [31:0] aIfAddr, aIfRdata, aDmAddr, aDmWdata, aDmRdata, aWdata, aRdata;
  logic [15:0] aAddr;
  // Instance B: WAIT_CYCLES = 0
  logic        bIfReq, bIfReady, bDmReq, bDmWe, bDmReady, bFreeze, bEn, bWe;
  logic [31:0] bIfAddr, bIfRdata, bDmAddr, bDmWdata, bDmRdata, bWdata, bRdata;
  logic [15:0] bAddr;

  logic [31:0] memA [0:255];
  logic [31:0] memB [0:255];
  exp_t qA[$];
  exp_t qB[$];

  mem_port_arbiter #(.ADDR_W(16), .WAIT_CYCLES(1)) dutA (
    .clk(clk), .rst(rst),
    .if_req(aIfReq), .if_addr(aIfAddr), .if_rdata(aIfRdata), .if_ready(aIfReady),
    .dm_req(aDmReq), .dm_we(aDmWe), .dm_addr(aDmAddr), .dm_wdata(aDmWdata),
    .dm_rdata(aDmRdata), .dm_ready(aDmReady), .pipe_freeze(aFreeze),
    .sram_en(aEn), .sram_we(aWe), .sram_addr(aAddr), .sram_wdata(aWdata), .sram_rdata(aRdata)
  );

  mem_port_arbiter #(.ADDR_W(16), .WAIT_CYCLES(0)) dutB (
    .clk(clk), .rst(rst),
    .if_req(bIfReq), .if_addr(bIfAddr), .if_rdata(bIfRdata), .if_ready(bIfReady),
    .dm_req(bDmReq), .dm_we(bDmWe), .dm_addr(bDmAddr), .dm_wdata(bDmWdata),
    .dm_rdata(bDmRdata), .dm_ready(bDmReady), .pipe_freeze(bFreeze),
    .sram_en(bEn), .sram_we(bWe), .sram_addr(bAddr), .sram_wdata(bWdata), .sram_rdata(bRdata)
  );

  assign aRdata = memA[aAddr[7:0]];
  assign bRdata = memB[bAddr[7:0]];

  // Memory models: preload a recognisable pattern, then apply writes on each edge.
  initial begin
    for (int i = 0; i < 256; i++) begin
      memA[i] = 32'hA500_0000 | i;
      memB[i] = 32'h5A00_0000 | i;
    end
    memA[4] = 32'hDEAD_BEEF;
    memA[8] = 32'hCAFE_F00D;
    memB[4] = 32'h0BAD_F00D;
    forever begin
      @(posedge clk);
      if (aEn && aWe) memA[aAddr[7:0]] = aWdata;
      if (bEn && bWe) memB[bAddr[7:0]] = bWdata;
    end
  end

  // Counts cycles in which instance A drives a memory write.
  always @(negedge clk) if (aEn && aWe) weCnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goCycle(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: every ready pulse pops one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (aIfReady || aDmReady) begin
      if (qA.size() == 0) begin
        checks++; failures++;
        $display("FAIL A_unexpected_ready actual=if%0b/dm%0b required=none (cycle %0d)", aIfReady, aDmReady, cyc);
      end else begin
        e = qA.pop_front();
        check("A_port_is_dm", 32'(aDmReady), 32'(e.isDm));
        check("A_rdata", e.isDm ? aDmRdata : aIfRdata, e.data);
        check("A_ready_cycle", 32'(cyc), e.cyc);
      end
    end
    if (bIfReady || bDmReady) begin
      if (qB.size() == 0) begin
        checks++; failures++;
        $display("FAIL B_unexpected_ready actual=if%0b/dm%0b required=none (cycle %0d)", bIfReady, bDmReady, cyc);
      end else begin
        e = qB.pop_front();
        check("B_port_is_dm", 32'(bDmReady), 32'(e.isDm));
        check("B_rdata", e.isDm ? bDmRdata : bIfRdata, e.data);
        check("B_ready_cycle", 32'(cyc), e.cyc);
      end
    end
  end

  initial begin
    int c;
    int weBase;
    rst = 1'b0;
    {aIfReq, aDmReq, aDmWe, bIfReq, bDmReq, bDmWe} = '0;
    {aIfAddr, aDmAddr, aDmWdata, bIfAddr, bDmAddr, bDmWdata} = '0;

    // Reset state
    @(negedge clk);
    check("rst_sram_en", 32'(aEn), 32'd0);
    check("rst_sram_we", 32'(aWe), 32'd0);
    check("rst_sram_addr", 32'(aAddr), 32'd0);
    check("rst_if_rdata", aIfRdata, 32'd0);
    check("rst_dm_rdata", aDmRdata, 32'd0);
    check("rst_ready", 32'({aIfReady, aDmReady, bIfReady, bDmReady}), 32'd0);
    check("rst_freeze", 32'({aFreeze, bFreeze}), 32'd0);
    goCycle(2);
    rst = 1'b1;

    // 1: single IF read, WAIT_CYCLES=1
    goCycle(3); c = cyc;
    aIfReq = 1'b1; aIfAddr = 32'h10;
    qA.push_back('{1'b0, 32'hDEAD_BEEF, 32'(c + 3)});
    @(negedge clk);
    check("t1_freeze_c0", 32'(aFreeze), 32'd1);
    check("t1_en_c0", 32'(aEn), 32'd0);
    goCycle(c + 1); @(negedge clk);
    check("t1_en_c1", 32'(aEn), 32'd1);
    check("t1_addr_c1", 32'(aAddr), 32'd4);
    goCycle(c + 2); @(negedge clk);
    check("t1_en_c2", 32'(aEn), 32'd1);
    check("t1_freeze_c2", 32'(aFreeze), 32'd1);
    goCycle(c + 3); @(negedge clk);
    check("t1_freeze_c3", 32'(aFreeze), 32'd0);
    check("t1_en_c3", 32'(aEn), 32'd0);
    goCycle(c + 4);
    aIfReq = 1'b0;

    // 2: simultaneous IF and DM, last grant IF -> DM first
    goCycle(c + 6); c = cyc;
    aIfReq = 1'b1; aIfAddr = 32'h14;
    aDmReq = 1'b1; aDmWe = 1'b0; aDmAddr = 32'h20;
    qA.push_back('{1'b1, 32'hCAFE_F00D, 32'(c + 3)});
    qA.push_back('{1'b0, 32'hA500_0005, 32'(c + 7)});
    goCycle(c + 3); @(negedge clk);
    check("t2_freeze_c3", 32'(aFreeze), 32'd1);
    goCycle(c + 5); @(negedge clk);
    check("t2_en_c5", 32'(aEn), 32'd1);
    check("t2_addr_c5", 32'(aAddr), 32'd5);
    goCycle(c + 6); @(negedge clk);
    check("t2_freeze_c6", 32'(aFreeze), 32'd1);
    goCycle(c + 7); @(negedge clk);
    check("t2_freeze_c7", 32'(aFreeze), 32'd0);
    goCycle(c + 8);
    aIfReq = 1'b0; aDmReq = 1'b0;

    // 3: DM write executes once, dm_rdata untouched, then read back
    goCycle(c + 10); c = cyc;
    weBase = weCnt;
    aDmReq = 1'b1; aDmWe = 1'b1; aDmAddr = 32'h8; aDmWdata = 32'h1234_5678;
    qA.push_back('{1'b1, 32'hCAFE_F00D, 32'(c + 3)});
    goCycle(c + 1); @(negedge clk);
    check("t3_we_c1", 32'(aWe), 32'd1);
    check("t3_addr_c1", 32'(aAddr), 32'd2);
    check("t3_wdata_c1", aWdata, 32'h1234_5678);
    goCycle(c + 3); @(negedge clk);
    check("t3_freeze_c3", 32'(aFreeze), 32'd0);
    goCycle(c + 4);
    aDmReq = 1'b0; aDmWe = 1'b0;
    @(negedge clk);
    check("t3_we_cycles", 32'(weCnt - weBase), 32'd2);
    check("t3_mem_word2", memA[2], 32'h1234_5678);
    goCycle(c + 5); c = cyc;
    aDmReq = 1'b1; aDmAddr = 32'h8;
    qA.push_back('{1'b1, 32'h1234_5678, 32'(c + 3)});
    goCycle(c + 4);
    aDmReq = 1'b0;

    // 4: fairness over two pipeline steps, last grant DM -> IF first each time
    goCycle(c + 6); c = cyc;
    aIfReq = 1'b1; aIfAddr = 32'h10;
    aDmReq = 1'b1; aDmAddr = 32'h20;
    qA.push_back('{1'b0, 32'hDEAD_BEEF, 32'(c + 3)});
    qA.push_back('{1'b1, 32'hCAFE_F00D, 32'(c + 7)});
    goCycle(c + 3); @(negedge clk);
    check("t4_freeze_c3", 32'(aFreeze), 32'd1);
    goCycle(c + 8);
    aIfAddr = 32'h18; aDmAddr = 32'h24;
    qA.push_back('{1'b0, 32'hA500_0006, 32'(c + 11)});
    qA.push_back('{1'b1, 32'hA500_0009, 32'(c + 15)});
    goCycle(c + 15); @(negedge clk);
    check("t4_freeze_c15", 32'(aFreeze), 32'd0);
    goCycle(c + 16);
    aIfReq = 1'b0; aDmReq = 1'b0;

    // 5: reset mid-access abandons the access with no ready pulse
    goCycle(c + 18); c = cyc;
    aIfReq = 1'b1; aIfAddr = 32'h10;
    goCycle(c + 1); @(negedge clk);
    check("t5_en_before_rst", 32'(aEn), 32'd1);
    goCycle(c + 2);
    #2;
    rst = 1'b0; aIfReq = 1'b0;
    #1;
    check("t5_en_in_rst", 32'(aEn), 32'd0);
    check("t5_ready_in_rst", 32'({aIfReady, aDmReady}), 32'd0);
    check("t5_if_rdata_rst", aIfRdata, 32'd0);
    goCycle(c + 4);
    rst = 1'b1;
    goCycle(c + 7); @(negedge clk);
    check("t5_idle_en", 32'(aEn), 32'd0);
    check("t5_idle_freeze", 32'(aFreeze), 32'd0);
    goCycle(c + 8); c = cyc;
    aIfReq = 1'b1; aIfAddr = 32'h10;
    qA.push_back('{1'b0, 32'hDEAD_BEEF, 32'(c + 3)});
    goCycle(c + 4);
    aIfReq = 1'b0;

    // 6: WAIT_CYCLES=0 instance, ready at N+2
    goCycle(c + 6); c = cyc;
    bDmReq = 1'b1; bDmAddr = 32'h10;
    qB.push_back('{1'b1, 32'h0BAD_F00D, 32'(c + 2)});
    goCycle(c + 1); @(negedge clk);
    check("t6_en_c1", 32'(bEn), 32'd1);
    check("t6_addr_c1", 32'(bAddr), 32'd4);
    goCycle(c + 2); @(negedge clk);
    check("t6_freeze_c2", 32'(bFreeze), 32'd0);
    check("t6_en_c2", 32'(bEn), 32'd0);
    goCycle(c + 3);
    bDmReq = 1'b0;
    goCycle(c + 4); c = cyc;
    bIfReq = 1'b1; bIfAddr = 32'h0C;
    qB.push_back('{1'b0, 32'h5A00_0003, 32'(c + 2)});
    goCycle(c + 3);
    bIfReq = 1'b0;

    // Every queued response must have been seen
    goCycle(c + 8);
    check("A_queue_drained", 32'(qA.size()), 32'd0);
    check("B_queue_drained", 32'(qB.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
